// File: rtl/fdc_spi_pkg.sv
// Shared constants, op encodings and FSM states for the FDC SPI command master.
package fdc_spi_pkg;

  localparam logic [7:0] SPI_CMD_ADDR  = 8'h01;
  localparam logic [7:0] SPI_CMD_WRITE = 8'h02;
  localparam logic [7:0] SPI_CMD_READ  = 8'h03;
  localparam logic [7:0] SPI_DUMMY     = 8'h00;

  localparam logic [1:0] OP_SET_ADDR = 2'd0;
  localparam logic [1:0] OP_WRITE    = 2'd1;
  localparam logic [1:0] OP_READ     = 2'd2;
  localparam logic [1:0] OP_RSVD     = 2'd3;

  typedef enum logic [2:0] {IDLE, SETUP, HIGH, LOW, GAP, FINISH} state_t;

  // Byte number idx of the frame sequence a command expands to; unused slots give the dummy byte.
  function automatic logic [7:0] cmd_byte(input logic [1:0] op, input logic [15:0] addr,
                                          input logic [7:0] wdata, input logic [1:0] idx);
    logic [7:0] b;
    b = SPI_DUMMY;
    case (idx)
      2'd0: begin
        case (op)
          OP_SET_ADDR: b = SPI_CMD_ADDR;
          OP_WRITE:    b = SPI_CMD_WRITE;
          OP_READ:     b = SPI_CMD_READ;
          default:     b = SPI_DUMMY;
        endcase
      end
      2'd1: begin
        if (op == OP_SET_ADDR) b = addr[15:8];
        else if (op == OP_WRITE) b = wdata;
      end
      2'd2: begin
        if (op == OP_SET_ADDR) b = addr[7:0];
      end
      default: b = SPI_DUMMY;
    endcase
    return b;
  endfunction

  function automatic logic [1:0] last_index(input logic [1:0] op);
    return (op == OP_SET_ADDR) ? 2'd2 : 2'd1;
  endfunction

endpackage

// File: rtl/fdc_spi_master_byte.sv
// Shifts one SS-framed mode-0 byte: SETUP, then eight HIGH/LOW half-periods of CLK_DIV cycles.
module spi_byte_master
  import fdc_spi_pkg::*;
#(
  parameter int CLK_DIV = 6
) (
  input  logic       clock_50,
  input  logic       reset,
  input  logic       start,
  input  logic [7:0] tx_byte,
  input  logic       miso,
  output logic       sclk,
  output logic       mosi,
  output logic       ss,
  output logic [7:0] rx_byte,
  output logic       byte_done
);

  state_t      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [2:0]  bit_q, bit_d;
  logic [6:0]  shift_q, shift_d;
  logic [7:0]  rx_q, rx_d;
  logic        sclk_q, sclk_d, mosi_q, mosi_d, ss_q, ss_d;
  logic        tick;

  assign tick = (cnt_q == 8'(CLK_DIV - 1));

  always_ff @(posedge clock_50 or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= 8'd0;
      bit_q   <= 3'd0;
      shift_q <= 7'd0;
      rx_q    <= 8'd0;
      sclk_q  <= 1'b0;
      mosi_q  <= 1'b0;
      ss_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      rx_q    <= rx_d;
      sclk_q  <= sclk_d;
      mosi_q  <= mosi_d;
      ss_q    <= ss_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = (state_q == IDLE || tick) ? 8'd0 : cnt_q + 8'd1;
    bit_d     = bit_q;
    shift_d   = shift_q;
    rx_d      = rx_q;
    sclk_d    = sclk_q;
    mosi_d    = mosi_q;
    ss_d      = ss_q;
    byte_done = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = SETUP;
          ss_d    = 1'b0;
          mosi_d  = tx_byte[7];
          shift_d = tx_byte[6:0];
          bit_d   = 3'd0;
        end
      end
      SETUP: begin
        if (tick) begin
          state_d = HIGH;
          sclk_d  = 1'b1;
          rx_d    = {rx_q[6:0], miso};
        end
      end
      HIGH: begin
        if (tick) begin
          state_d = LOW;
          sclk_d  = 1'b0;
          // After the last bit MOSI is simply held through the closing LOW phase.
          if (bit_q != 3'd7) begin
            mosi_d  = shift_q[6];
            shift_d = {shift_q[5:0], 1'b0};
          end
        end
      end
      LOW: begin
        if (tick) begin
          if (bit_q == 3'd7) begin
            state_d   = IDLE;
            ss_d      = 1'b1;
            mosi_d    = 1'b0;
            byte_done = 1'b1;
          end else begin
            state_d = HIGH;
            bit_d   = bit_q + 3'd1;
            sclk_d  = 1'b1;
            rx_d    = {rx_q[6:0], miso};
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign sclk    = sclk_q;
  assign mosi    = mosi_q;
  assign ss      = ss_q;
  assign rx_byte = rx_q;

endmodule

// File: rtl/fdc_spi_master.sv
// Expands host commands into FDC SPI byte sequences with inter-byte gaps and captures READ data.
module fdc_spi_master
  import fdc_spi_pkg::*;
#(
  parameter int CLK_DIV    = 6,
  parameter int GAP_CYCLES = 24
) (
  input  logic        clock_50,
  input  logic        reset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [1:0]  cmd_op,
  input  logic [15:0] cmd_addr,
  input  logic [7:0]  cmd_wdata,
  output logic        done,
  output logic [7:0]  rdata,
  output logic        busy,
  output logic        sclk,
  output logic        mosi,
  input  logic        miso,
  output logic        ss
);

  state_t      state_q, state_d;
  logic [1:0]  op_q, op_d;
  logic [15:0] addr_q, addr_d;
  logic [7:0]  wdata_q, wdata_d;
  logic [1:0]  idx_q, idx_d;
  logic [7:0]  gap_q, gap_d;
  logic [7:0]  rdata_q, rdata_d;
  logic        start, byte_done;
  logic [7:0]  tx_byte, rx_byte;

  spi_byte_master #(.CLK_DIV(CLK_DIV)) u_byte (
    .clock_50  (clock_50),
    .reset     (reset),
    .start     (start),
    .tx_byte   (tx_byte),
    .miso      (miso),
    .sclk      (sclk),
    .mosi      (mosi),
    .ss        (ss),
    .rx_byte   (rx_byte),
    .byte_done (byte_done)
  );

  always_ff @(posedge clock_50 or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      op_q    <= OP_SET_ADDR;
      addr_q  <= 16'd0;
      wdata_q <= 8'd0;
      idx_q   <= 2'd0;
      gap_q   <= 8'd0;
      rdata_q <= 8'd0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      idx_q   <= idx_d;
      gap_q   <= gap_d;
      rdata_q <= rdata_d;
    end
  end

  // SETUP here means "a byte is in flight"; the HIGH/LOW detail lives in spi_byte_master.
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    idx_d   = idx_q;
    gap_d   = gap_q;
    rdata_d = rdata_q;
    start   = 1'b0;
    tx_byte = SPI_DUMMY;
    case (state_q)
      IDLE, FINISH: begin
        state_d = IDLE;
        if (cmd_valid) begin
          op_d    = cmd_op;
          addr_d  = cmd_addr;
          wdata_d = cmd_wdata;
          idx_d   = 2'd0;
          if (cmd_op == OP_RSVD) begin
            state_d = FINISH;
          end else begin
            state_d = SETUP;
            start   = 1'b1;
            tx_byte = cmd_byte(cmd_op, cmd_addr, cmd_wdata, 2'd0);
          end
        end
      end
      SETUP: begin
        if (byte_done) begin
          state_d = GAP;
          gap_d   = 8'd0;
        end
      end
      GAP: begin
        if (gap_q == 8'(GAP_CYCLES - 1)) begin
          if (idx_q == last_index(op_q)) begin
            state_d = FINISH;
            if (op_q == OP_READ) rdata_d = rx_byte;
          end else begin
            state_d = SETUP;
            idx_d   = idx_q + 2'd1;
            start   = 1'b1;
            tx_byte = cmd_byte(op_q, addr_q, wdata_q, idx_q + 2'd1);
          end
        end else begin
          gap_d = gap_q + 8'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign cmd_ready = (state_q == IDLE) || (state_q == FINISH);
  assign busy      = ~cmd_ready;
  assign done      = (state_q == FINISH);
  assign rdata     = rdata_q;

endmodule

// File: tb/tb_fdc_spi_master.sv
// Directed bench for fdc_spi_master with a mode-0 SPI slave model that records MOSI frames.
module tb_fdc_spi_master;
  import fdc_spi_pkg::*;

  logic        clock_50;
  logic        reset;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [1:0]  cmd_op;
  logic [15:0] cmd_addr;
  logic [7:0]  cmd_wdata;
  logic        done;
  logic [7:0]  rdata;
  logic        busy;
  logic        sclk;
  logic        mosi;
  logic        miso;
  logic        ss;

  int compareCount = 0;
  int failCount    = 0;

  fdc_spi_master #(.CLK_DIV(6), .GAP_CYCLES(24)) dut (
    .clock_50  (clock_50),
    .reset     (reset),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .cmd_addr  (cmd_addr),
    .cmd_wdata (cmd_wdata),
    .done      (done),
    .rdata     (rdata),
    .busy      (busy),
    .sclk      (sclk),
    .mosi      (mosi),
    .miso      (miso),
    .ss        (ss)
  );

  initial clock_50 = 1'b0;
  always #10 clock_50 = ~clock_50;

  // Slave model: shifts MISO out on SS fall and falling SCK, samples MOSI on rising SCK,
  // keeps only complete 8-edge frames, and answers a 0x03 command with its read buffer.
  logic [7:0] frames[$];
  logic [7:0] expFrames[$];
  logic [7:0] sRx = 8'h00;
  logic [7:0] sTx = 8'hFF;
  logic [7:0] sLast = 8'h00;
  logic [7:0] sReadBuf = 8'h00;
  logic       prevSs = 1'b1;
  logic       prevSclk = 1'b0;
  int         sEdges = 0;
  int         frameCount = 0;
  int         badFrames = 0;
  int         sclkBad = 0;
  time        tLastRise = 0;
  time        tSsRise = 0;
  int         lastPeriod = 0;
  int         lastGap = 0;

  initial miso = 1'b0;

  always @(ss or sclk) begin
    if (ss !== prevSs) begin
      if (reset === 1'b1 && sclk === 1'b1) sclkBad++;
      if (ss === 1'b0) begin
        sEdges = 0;
        sTx = (sLast == 8'h03) ? sReadBuf : 8'hFF;
        miso = sTx[7];
        lastGap = int'(($time - tSsRise) / 20);
      end else if (ss === 1'b1) begin
        tSsRise = $time;
        if (sEdges == 8) begin
          frames.push_back(sRx);
          sLast = sRx;
          frameCount++;
        end else if (reset === 1'b1) begin
          badFrames++;
        end
      end
    end
    if (sclk !== prevSclk) begin
      if (ss === 1'b1 && reset === 1'b1) sclkBad++;
      else if (sclk === 1'b1) begin
        sRx = {sRx[6:0], mosi};
        if (sEdges > 0) lastPeriod = int'(($time - tLastRise) / 20);
        tLastRise = $time;
        sEdges++;
      end else if (sclk === 1'b0) begin
        sTx = {sTx[6:0], 1'b1};
        miso = sTx[7];
      end
    end
    prevSs = ss;
    prevSclk = sclk;
  end

  int         doneCount = 0;
  logic [7:0] rdataAtDone = 8'h00;

  always @(negedge clock_50) begin
    if (done === 1'b1) begin
      doneCount++;
      rdataAtDone = rdata;
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    compareCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
    end
  endtask

  task automatic checkFrames(input string tag);
    logic [7:0] got;
    checkOutput({tag, "_nframes"}, frames.size(), expFrames.size());
    for (int i = 0; i < expFrames.size(); i++) begin
      got = (i < frames.size()) ? frames[i] : 8'hxx;
      checkOutput($sformatf("%s_byte%0d", tag, i), {24'h0, got}, {24'h0, expFrames[i]});
    end
  endtask

  task automatic applyStimulus(input logic [1:0] op, input logic [15:0] addr,
                               input logic [7:0] wdata, output time tAcc);
    int n;
    @(negedge clock_50);
    cmd_op = op;
    cmd_addr = addr;
    cmd_wdata = wdata;
    cmd_valid = 1'b1;
    n = 0;
    while (cmd_ready !== 1'b1 && n < 2000) begin
      @(negedge clock_50);
      n++;
    end
    if (cmd_ready !== 1'b1) checkOutput("accept_timeout", 32'd0, 32'd1);
    @(posedge clock_50);
    tAcc = $time;
    @(negedge clock_50);
    cmd_valid = 1'b0;
  endtask

  task automatic waitDone(input string tag, input int limit, output time tDone);
    int n;
    n = 0;
    tDone = 0;
    while (done !== 1'b1 && n < limit) begin
      @(negedge clock_50);
      n++;
    end
    if (done !== 1'b1) checkOutput({tag, "_done_timeout"}, 32'd0, 32'd1);
    else tDone = $time;
  endtask

  time tAcc, tDone;
  int  doneBase, accInDone, guard, idx;
  logic [1:0]  seqOp[4];
  logic [15:0] seqAddr[4];
  logic [7:0]  seqData[4];

  initial begin
    reset = 1'b0;
    cmd_valid = 1'b0;
    cmd_op = OP_SET_ADDR;
    cmd_addr = 16'h0000;
    cmd_wdata = 8'h00;
    repeat (3) @(negedge clock_50);
    checkOutput("reset_ss", ss, 1);
    checkOutput("reset_sclk", sclk, 0);
    checkOutput("reset_mosi", mosi, 0);
    checkOutput("reset_done", done, 0);
    checkOutput("reset_rdata", rdata, 8'h00);
    checkOutput("reset_cmd_ready", cmd_ready, 1);
    checkOutput("reset_busy", busy, 0);
    reset = 1'b1;
    repeat (2) @(negedge clock_50);

    // 1: SET_ADDR 0x1234
    $display("[TB] SET_ADDR 1234");
    frames.delete();
    doneBase = doneCount;
    applyStimulus(OP_SET_ADDR, 16'h1234, 8'h00, tAcc);
    checkOutput("t1_busy_after_accept", busy, 1);
    waitDone("t1", 1000, tDone);
    checkOutput("t1_latency", int'((tDone - 10 - tAcc) / 20), 378);
    @(negedge clock_50);
    checkOutput("t1_done_single", done, 0);
    expFrames = '{8'h01, 8'h12, 8'h34};
    checkFrames("t1");
    checkOutput("t1_done_count", doneCount - doneBase, 1);

    // 2 + 4: WRITE 0xA5, timing
    $display("[TB] WRITE A5");
    frames.delete();
    doneBase = doneCount;
    applyStimulus(OP_WRITE, 16'hFFFF, 8'hA5, tAcc);
    cmd_wdata = 8'h11;
    waitDone("t2", 1000, tDone);
    checkOutput("t4_write_latency", int'((tDone - 10 - tAcc) / 20), 252);
    checkOutput("t2_rdata_at_done", rdata, 8'h00);
    repeat (3) @(negedge clock_50);
    expFrames = '{8'h02, 8'hA5};
    checkFrames("t2");
    checkOutput("t2_done_count", doneCount - doneBase, 1);
    checkOutput("t4_sclk_period", lastPeriod, 12);
    checkOutput("t4_ss_gap", lastGap, 24);

    // 3: READ returning 0x5C
    $display("[TB] READ 5C");
    frames.delete();
    sReadBuf = 8'h5C;
    applyStimulus(OP_READ, 16'h0000, 8'h00, tAcc);
    waitDone("t3", 1000, tDone);
    checkOutput("t3_rdata_at_done", rdata, 8'h5C);
    repeat (10) @(negedge clock_50);
    checkOutput("t3_rdata_held", rdata, 8'h5C);
    expFrames = '{8'h03, 8'h00};
    checkFrames("t3");

    // 5: back-to-back commands with cmd_valid held high
    $display("[TB] back-to-back commands");
    frames.delete();
    sReadBuf = 8'h81;
    doneBase = doneCount;
    seqOp   = '{OP_WRITE, OP_RSVD, OP_SET_ADDR, OP_READ};
    seqAddr = '{16'h0000, 16'h5555, 16'hBEEF, 16'h0000};
    seqData = '{8'h3C, 8'h77, 8'h00, 8'h00};
    accInDone = 0;
    idx = 0;
    guard = 0;
    @(negedge clock_50);
    cmd_op = seqOp[0];
    cmd_addr = seqAddr[0];
    cmd_wdata = seqData[0];
    cmd_valid = 1'b1;
    while (idx < 4 && guard < 3000) begin
      if (cmd_ready === 1'b1) begin
        if (idx > 0 && done === 1'b1) accInDone++;
        @(negedge clock_50);
        idx++;
        if (idx < 4) begin
          cmd_op = seqOp[idx];
          cmd_addr = seqAddr[idx];
          cmd_wdata = seqData[idx];
        end else begin
          cmd_valid = 1'b0;
        end
      end else begin
        @(negedge clock_50);
      end
      guard++;
    end
    cmd_valid = 1'b0;
    checkOutput("t5_all_accepted", idx, 4);
    waitDone("t5", 1000, tDone);
    repeat (3) @(negedge clock_50);
    checkOutput("t5_accept_in_done", accInDone, 3);
    checkOutput("t5_done_count", doneCount - doneBase, 4);
    checkOutput("t5_rdata", rdata, 8'h81);
    expFrames = '{8'h02, 8'h3C, 8'h01, 8'hBE, 8'hEF, 8'h03, 8'h00};
    checkFrames("t5");

    // 6: reset during bit 4 of the second READ byte
    $display("[TB] reset mid-READ");
    sReadBuf = 8'h6A;
    doneBase = frameCount;
    applyStimulus(OP_READ, 16'h0000, 8'h00, tAcc);
    guard = 0;
    while (!(frameCount == doneBase + 1 && sEdges == 5) && guard < 400) begin
      @(negedge clock_50);
      guard++;
    end
    checkOutput("t6_reached_bit4", (frameCount == doneBase + 1 && sEdges == 5) ? 1 : 0, 1);
    doneBase = doneCount;
    reset = 1'b0;
    @(negedge clock_50);
    checkOutput("t6_rst_ss", ss, 1);
    checkOutput("t6_rst_sclk", sclk, 0);
    checkOutput("t6_rst_mosi", mosi, 0);
    checkOutput("t6_rst_done", done, 0);
    checkOutput("t6_rst_rdata", rdata, 8'h00);
    checkOutput("t6_rst_cmd_ready", cmd_ready, 1);
    repeat (4) @(negedge clock_50);
    reset = 1'b1;
    repeat (5) @(negedge clock_50);
    checkOutput("t6_no_done_pulse", doneCount - doneBase, 0);
    checkOutput("t6_rdata_after_release", rdata, 8'h00);
    frames.delete();
    sReadBuf = 8'hC3;
    applyStimulus(OP_READ, 16'h0000, 8'h00, tAcc);
    waitDone("t6", 1000, tDone);
    checkOutput("t6_read_rdata", rdata, 8'hC3);
    repeat (3) @(negedge clock_50);
    checkOutput("t6_rdata_at_done", rdataAtDone, 8'hC3);
    expFrames = '{8'h03, 8'h00};
    checkFrames("t6");

    checkOutput("sclk_idle_while_ss_high", sclkBad, 0);
    checkOutput("incomplete_frames", badFrames, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, failCount);
    $finish;
  end

endmodule

// File: doc/fdc_spi_master.md
Name: fdc_spi_master

Overview:
SPI master that drives the FDC emulator's SPI command protocol from the host/companion-logic side of the board. It converts single-word commands (set address, write byte, read byte) into the byte sequences the CPLD's SPI slave decodes: 0x01 hi lo, 0x02 data, 0x03 dummy. It generates SCK, SS and MOSI, samples MISO, and returns read data. The inter-byte gap gives the slave time to finish its SRAM cycle.

Parameters:
CLK_DIV, 6, SCK half-period in clock_50 cycles (6 gives 4.17 MHz); legal range 2..255.
GAP_CYCLES, 24, clock_50 cycles SS stays high between bytes; must be at least 16 to cover slave sync plus its SRAM cycle.

Ports:
clock_50  in  1  system clock, 50 MHz
reset  in  1  asynchronous, active-low
cmd_valid  in  1  command request
cmd_ready  out  1  high when idle; command accepted when cmd_valid & cmd_ready
cmd_op  in  2  0 = SET_ADDR, 1 = WRITE, 2 = READ, 3 = reserved
cmd_addr  in  16  address for SET_ADDR
cmd_wdata  in  8  data for WRITE
done  out  1  one-cycle pulse when a command completes
rdata  out  8  READ result; updated in the done cycle of a READ, held otherwise
busy  out  1  equals ~cmd_ready
sclk  out  1  SPI clock, mode 0 (CPOL=0, CPHA=0)
mosi  out  1  master out, MSB first
miso  in  1  master in
ss  out  1  slave select, active-low, framed per byte

Behaviour:
- Reset values: sclk=0, ss=1, mosi=0, done=0, rdata=8'h00, cmd_ready=1. FSM goes to IDLE and byte index goes to 0.
- Reset mid-transfer aborts immediately with no done pulse. The slave sees SS rise and drops its partial byte.
- FSM states: IDLE, SETUP, HIGH, LOW, GAP, FINISH.
- Accept: on cmd_valid & cmd_ready, latch op/addr/wdata and build the byte list:
  - SET_ADDR: {8'h01, addr[15:8], addr[7:0]}, 3 bytes
  - WRITE: {8'h02, wdata}, 2 bytes
  - READ: {8'h03, 8'h00}, 2 bytes
  - op 3: no bytes; go straight to FINISH, so done pulses on the cycle after accept.
  - cmd_ready drops on the cycle after accept.
- Byte framing, per byte:
  - SETUP: ss=0 and mosi=bit7; hold CLK_DIV cycles.
  - HIGH: sclk=1, sample miso into shift[0] on entry; hold CLK_DIV cycles.
  - LOW: sclk=0, shift left, mosi=next bit; hold CLK_DIV cycles.
  - HIGH/LOW repeat 8 times. After the 8th HIGH, the final LOW holds CLK_DIV cycles, then ss=1 and mosi=0.
- GAP: ss=1 for GAP_CYCLES cycles. Then start the next byte, or go to FINISH after the last byte.
- Byte time is exactly (1 + 16)·CLK_DIV + GAP_CYCLES cycles; the default is 126.
- Read capture: MISO bits from the 2nd byte of READ form rdata, MSB first. This is the slave's readbuf, loaded after it decoded 0x03. MISO from all other bytes is discarded.
- FINISH: done=1 for exactly one cycle, rdata updated if the op was READ, cmd_ready=1 the same cycle. A new command may be accepted in that cycle, with no extra idle cycle.
- cmd_valid while busy is ignored, not queued. Latched fields never change mid-command.
- SCK never toggles while ss=1. sclk is always 0 when ss changes.
- Address auto-increment belongs to the slave. This block keeps no address state.
- Counters: half-period counter 8 bits, gap counter 8 bits, bit counter 3 bits, byte index 2 bits. No wrap beyond byte count.

Decomposition:
- Shared package fdc_spi_pkg holds:
  - command byte constants SPI_CMD_ADDR=8'h01, SPI_CMD_WRITE=8'h02, SPI_CMD_READ=8'h03, SPI_DUMMY=8'h00
  - cmd_op encodings OP_SET_ADDR / OP_WRITE / OP_READ
  - FSM state encodings
- One sub-module, spi_byte_master: shifts a single byte with SETUP/HIGH/LOW timing and a start/done handshake.
- The top level sequences bytes, inserts gaps, and captures read data.

Test Plan:
1. SET_ADDR 16'h1234 -> three SS-low frames with MOSI bytes 01, 12, 34. Each frame has 8 sclk rising edges; done is a single pulse after the 3rd gap.
2. WRITE 8'hA5 -> MOSI frames 02, A5. rdata stays unchanged (reset value 00); done pulses once.
3. READ with a mode-0 slave model returning 8'h5C on byte 2 (byte 1 MISO=FF) -> MOSI frames 03, 00; rdata=5C in the done cycle and held.
4. With default params, measure the sclk period = 12 cycles and the SS-high gap = 24 cycles. Total WRITE latency from accept to done = 2·126 cycles ±1.
5. Assert cmd_valid continuously with varied ops -> each command is accepted only when cmd_ready=1. The next command is accepted in the done cycle; no bytes are lost or duplicated.
6. Assert reset during bit 4 of the 2nd READ byte -> within the reset window ss=1, sclk=0, mosi=0, no done pulse, rdata=00. After release, a new READ completes correctly.
